// File: rtl/load_rs_mp.sv
// Multi-port load reservation station.
// Wakes loads from the CDB, orders them behind older stores, forwards bytes from the store buffer and returns results oldest-first.
module load_rs_mp #(
    parameter int LOAD_RS_DEPTH      = 3,
    parameter int NUM_PORTS          = 2,
    parameter int ROB_DEPTH          = 3,
    parameter int STORE_RS_DEPTH     = 3,
    parameter int STORE_BUFFER_DEPTH = 3,
    parameter int CDB_SIZE           = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      move_flush,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic [2:0]                issue_funct3,
    input  logic [31:0]               issue_imm,
    input  logic [ROB_DEPTH-1:0]      issue_target_rob,
    input  logic                      issue_rs1_ready,
    input  logic [31:0]               issue_rs1_v,
    input  logic [ROB_DEPTH-1:0]      issue_rs1_rob,
    input  logic [STORE_RS_DEPTH:0]   issue_store_count,
    input  logic                      store_rs_pop,
    input  logic [CDB_SIZE-1:0]       cdb_valid,
    input  logic [ROB_DEPTH-1:0]      cdb_rob [CDB_SIZE],
    input  logic [31:0]               cdb_rd_v [CDB_SIZE],
    input  logic [(1<<STORE_BUFFER_DEPTH)-1:0] sb_valid,
    input  logic [31:0]               sb_addr [1<<STORE_BUFFER_DEPTH],
    input  logic [3:0]                sb_wmask [1<<STORE_BUFFER_DEPTH],
    input  logic [31:0]               sb_wdata [1<<STORE_BUFFER_DEPTH],
    output logic [NUM_PORTS-1:0]      dmem_req_valid,
    input  logic [NUM_PORTS-1:0]      dmem_req_ready,
    output logic [31:0]               dmem_req_addr [NUM_PORTS],
    output logic [3:0]                dmem_req_rmask [NUM_PORTS],
    output logic [LOAD_RS_DEPTH:0]    dmem_req_tag [NUM_PORTS],
    input  logic [NUM_PORTS-1:0]      dmem_resp_valid,
    input  logic [LOAD_RS_DEPTH:0]    dmem_resp_tag [NUM_PORTS],
    input  logic [31:0]               dmem_resp_rdata [NUM_PORTS],
    output logic                      cdb_out_valid,
    input  logic                      cdb_out_ready,
    output logic [ROB_DEPTH-1:0]      cdb_out_rob,
    output logic [31:0]               cdb_out_v,
    output logic [31:0]               cdb_out_addr,
    output logic [3:0]                cdb_out_rmask,
    output logic [31:0]               cdb_out_rdata
);

    localparam int N  = 1 << LOAD_RS_DEPTH;
    localparam int IW = LOAD_RS_DEPTH;
    localparam int SB = 1 << STORE_BUFFER_DEPTH;
    localparam int CW = STORE_RS_DEPTH + 1;

    typedef logic [IW-1:0] idx_t;
    typedef logic [IW:0]   rank_t;
    typedef logic [CW-1:0] cnt_t;

    typedef enum logic [2:0] {
        S_FREE,
        S_WAIT,
        S_READY,
        S_ISSUED,
        S_DONE
    } state_t;

    typedef struct packed {
        state_t               st;
        logic [2:0]           f3;
        logic [31:0]          imm;
        logic [ROB_DEPTH-1:0] rob;
        logic                 rdy;
        logic [31:0]          rs1;
        logic [ROB_DEPTH-1:0] tag;
        cnt_t                 cnt;
        logic                 ep;
        logic [3:0]           fmask;
        logic [31:0]          fdata;
        logic [31:0]          word;
    } entry_t;

    entry_t        ent_q [N];
    entry_t        ent_d [N];
    logic [N-1:0]  older_q [N];

    logic [31:0]   addr_c [N];
    logic [3:0]    rmask_c [N];
    logic [3:0]    fmask_c [N];
    logic [31:0]   fdata_c [N];
    logic [N-1:0]  full_c;
    logic [N-1:0]  valid_c;
    logic [N-1:0]  elig;
    rank_t         rank [N];
    idx_t          pidx [NUM_PORTS];
    logic [N-1:0]  grant;

    logic          alloc;
    idx_t          alloc_idx;
    logic          al_rdy;
    logic [31:0]   al_v;
    cnt_t          al_cnt;

    logic [N-1:0]  cand;
    logic [N-1:0]  has_older;
    logic          sel_ok;
    idx_t          sel_idx;
    idx_t          out_idx_q;
    logic          out_fire;

    function automatic logic [3:0] rmask_of(
        input logic [2:0] f3,
        input logic [1:0] a
    );
        case (f3[1:0])
            2'b00:   rmask_of = 4'b0001 << a;
            2'b01:   rmask_of = 4'b0011 << a;
            default: rmask_of = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ext_of(
        input logic [2:0]  f3,
        input logic [1:0]  a,
        input logic [31:0] w
    );
        logic [31:0] s;
        s = w >> {a, 3'b000};
        case (f3)
            3'b000:  ext_of = {{24{s[7]}}, s[7:0]};
            3'b001:  ext_of = {{16{s[15]}}, s[15:0]};
            3'b100:  ext_of = {24'd0, s[7:0]};
            3'b101:  ext_of = {16'd0, s[15:0]};
            default: ext_of = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(
        input logic [3:0]  m,
        input logic [31:0] f,
        input logic [31:0] r
    );
        for (int b = 0; b < 4; b++) begin
            merge[8*b +: 8] = m[b] ? f[8*b +: 8] : r[8*b +: 8];
        end
    endfunction

    assign out_fire = cdb_out_valid && cdb_out_ready;

    // Address, byte mask and store-buffer forwarding per entry.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            addr_c[i]  = ent_q[i].rs1 + ent_q[i].imm;
            rmask_c[i] = rmask_of(ent_q[i].f3, addr_c[i][1:0]);
            fmask_c[i] = '0;
            fdata_c[i] = '0;
            for (int b = 0; b < 4; b++) begin
                for (int s = SB - 1; s >= 0; s--) begin
                    if (sb_valid[s] && sb_wmask[s][b] && rmask_c[i][b] &&
                        ((sb_addr[s] & ~32'h3) ==
                         (addr_c[i] & ~32'h3))) begin
                        fmask_c[i][b]        = 1'b1;
                        fdata_c[i][8*b +: 8] = sb_wdata[s][8*b +: 8];
                    end
                end
            end
            full_c[i]  = (fmask_c[i] & rmask_c[i]) == rmask_c[i];
            valid_c[i] = ent_q[i].st != S_FREE;
            elig[i]    = (ent_q[i].st == S_READY) && !full_c[i];
        end
    end

    // Port p carries the p-th oldest request-eligible entry.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            rank[i] = '0;
            for (int j = 0; j < N; j++) begin
                if (elig[j] && older_q[j][i]) begin
                    rank[i] = rank[i] + rank_t'(1);
                end
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            dmem_req_valid[p] = 1'b0;
            dmem_req_addr[p]  = '0;
            dmem_req_rmask[p] = '0;
            dmem_req_tag[p]   = '0;
            pidx[p]           = '0;
            for (int i = 0; i < N; i++) begin
                if (elig[i] && rank[i] == rank_t'(p)) begin
                    dmem_req_valid[p] = 1'b1;
                    dmem_req_addr[p]  = addr_c[i] & ~32'h3;
                    dmem_req_rmask[p] = rmask_c[i];
                    dmem_req_tag[p]   = {ent_q[i].ep, idx_t'(i)};
                    pidx[p]           = idx_t'(i);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            grant[i] = 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (dmem_req_valid[p] && dmem_req_ready[p] &&
                    pidx[p] == idx_t'(i)) begin
                    grant[i] = 1'b1;
                end
            end
        end
    end

    // Lowest free slot plus operand and store-count capture for a new load.
    always_comb begin
        issue_ready = 1'b0;
        alloc_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ent_q[i].st == S_FREE) begin
                issue_ready = 1'b1;
                alloc_idx   = idx_t'(i);
            end
        end
        alloc  = issue_valid && issue_ready && !move_flush;
        al_rdy = issue_rs1_ready;
        al_v   = issue_rs1_v;
        if (!issue_rs1_ready) begin
            for (int c = 0; c < CDB_SIZE; c++) begin
                if (cdb_valid[c] && cdb_rob[c] == issue_rs1_rob) begin
                    al_rdy = 1'b1;
                    al_v   = cdb_rd_v[c];
                end
            end
        end
        al_cnt = issue_store_count;
        if (store_rs_pop && al_cnt != '0) begin
            al_cnt = al_cnt - cnt_t'(1);
        end
    end

    // Oldest finished entry not already sitting in the output register.
    always_comb begin
        sel_ok  = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand[i] = (ent_q[i].st == S_DONE) &&
                      !(cdb_out_valid && out_idx_q == idx_t'(i));
        end
        for (int i = 0; i < N; i++) begin
            has_older[i] = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (cand[j] && older_q[j][i]) begin
                    has_older[i] = 1'b1;
                end
            end
            if (cand[i] && !has_older[i]) begin
                sel_ok  = 1'b1;
                sel_idx = idx_t'(i);
            end
        end
    end

    // Per-entry next state: wake, count, forward, issue, respond, retire.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            ent_d[i] = ent_q[i];
            if (store_rs_pop && ent_q[i].cnt != '0) begin
                ent_d[i].cnt = ent_q[i].cnt - cnt_t'(1);
            end
            case (ent_q[i].st)
                S_WAIT: begin
                    if (!ent_q[i].rdy) begin
                        for (int c = 0; c < CDB_SIZE; c++) begin
                            if (cdb_valid[c] &&
                                cdb_rob[c] == ent_q[i].tag) begin
                                ent_d[i].rdy = 1'b1;
                                ent_d[i].rs1 = cdb_rd_v[c];
                            end
                        end
                    end
                    if (ent_q[i].rdy && ent_q[i].cnt == '0) begin
                        ent_d[i].st = S_READY;
                    end
                end
                S_READY: begin
                    if (full_c[i]) begin
                        ent_d[i].st   = S_DONE;
                        ent_d[i].word = fdata_c[i];
                    end else if (grant[i]) begin
                        ent_d[i].st    = S_ISSUED;
                        ent_d[i].fmask = fmask_c[i];
                        ent_d[i].fdata = fdata_c[i];
                    end
                end
                S_ISSUED: begin
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (dmem_resp_valid[p] &&
                            dmem_resp_tag[p] ==
                            {ent_q[i].ep, idx_t'(i)}) begin
                            ent_d[i].st   = S_DONE;
                            ent_d[i].word = merge(ent_q[i].fmask,
                                                  ent_q[i].fdata,
                                                  dmem_resp_rdata[p]);
                        end
                    end
                end
                S_DONE: begin
                    if (out_fire && out_idx_q == idx_t'(i)) begin
                        ent_d[i].st = S_FREE;
                    end
                end
                default: ;
            endcase
            if (alloc && alloc_idx == idx_t'(i)) begin
                ent_d[i].st    = (al_rdy && al_cnt == '0) ?
                                 S_READY : S_WAIT;
                ent_d[i].f3    = issue_funct3;
                ent_d[i].imm   = issue_imm;
                ent_d[i].rob   = issue_target_rob;
                ent_d[i].rdy   = al_rdy;
                ent_d[i].rs1   = al_v;
                ent_d[i].tag   = issue_rs1_rob;
                ent_d[i].cnt   = al_cnt;
                ent_d[i].fmask = '0;
                ent_d[i].fdata = '0;
                ent_d[i].word  = '0;
            end
            if (move_flush) begin
                ent_d[i].st = S_FREE;
                ent_d[i].ep = ~ent_q[i].ep;
            end
        end
    end

    // Entry state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    // Age matrix: older_q[j][i] means entry j is older than entry i.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                older_q[i] <= '0;
            end
        end else if (alloc) begin
            for (int j = 0; j < N; j++) begin
                older_q[alloc_idx][j] <= 1'b0;
                older_q[j][alloc_idx] <= valid_c[j];
            end
        end
    end

    // Registered result slot, held until the consumer takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_out_valid <= 1'b0;
            cdb_out_rob   <= '0;
            cdb_out_v     <= '0;
            cdb_out_addr  <= '0;
            cdb_out_rmask <= '0;
            cdb_out_rdata <= '0;
            out_idx_q     <= '0;
        end else if (move_flush) begin
            cdb_out_valid <= 1'b0;
        end else if (!cdb_out_valid || cdb_out_ready) begin
            cdb_out_valid <= sel_ok;
            if (sel_ok) begin
                out_idx_q     <= sel_idx;
                cdb_out_rob   <= ent_q[sel_idx].rob;
                cdb_out_addr  <= addr_c[sel_idx];
                cdb_out_rmask <= rmask_c[sel_idx];
                cdb_out_rdata <= ent_q[sel_idx].word;
                cdb_out_v     <= ext_of(ent_q[sel_idx].f3,
                                        addr_c[sel_idx][1:0],
                                        ent_q[sel_idx].word);
            end
        end
    end

endmodule

// File: tb/tb_load_rs_mp.sv
// Directed bench for load_rs_mp.
// Hand-computed expectations for issue, forwarding, ordering, flush and reset.
module tb_load_rs_mp;

    logic        clk;
    logic        rst;
    logic        move_flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  issue_funct3;
    logic [31:0] issue_imm;
    logic [2:0]  issue_target_rob;
    logic        issue_rs1_ready;
    logic [31:0] issue_rs1_v;
    logic [2:0]  issue_rs1_rob;
    logic [3:0]  issue_store_count;
    logic        store_rs_pop;
    logic [3:0]  cdb_valid;
    logic [2:0]  cdb_rob [4];
    logic [31:0] cdb_rd_v [4];
    logic [7:0]  sb_valid;
    logic [31:0] sb_addr [8];
    logic [3:0]  sb_wmask [8];
    logic [31:0] sb_wdata [8];
    logic [1:0]  dmem_req_valid;
    logic [1:0]  dmem_req_ready;
    logic [31:0] dmem_req_addr [2];
    logic [3:0]  dmem_req_rmask [2];
    logic [3:0]  dmem_req_tag [2];
    logic [1:0]  dmem_resp_valid;
    logic [3:0]  dmem_resp_tag [2];
    logic [31:0] dmem_resp_rdata [2];
    logic        cdb_out_valid;
    logic        cdb_out_ready;
    logic [2:0]  cdb_out_rob;
    logic [31:0] cdb_out_v;
    logic [31:0] cdb_out_addr;
    logic [3:0]  cdb_out_rmask;
    logic [31:0] cdb_out_rdata;

    int n_chk;
    int n_pass;

    load_rs_mp dut (
        .clk               (clk),
        .rst               (rst),
        .move_flush        (move_flush),
        .issue_valid       (issue_valid),
        .issue_ready       (issue_ready),
        .issue_funct3      (issue_funct3),
        .issue_imm         (issue_imm),
        .issue_target_rob  (issue_target_rob),
        .issue_rs1_ready   (issue_rs1_ready),
        .issue_rs1_v       (issue_rs1_v),
        .issue_rs1_rob     (issue_rs1_rob),
        .issue_store_count (issue_store_count),
        .store_rs_pop      (store_rs_pop),
        .cdb_valid         (cdb_valid),
        .cdb_rob           (cdb_rob),
        .cdb_rd_v          (cdb_rd_v),
        .sb_valid          (sb_valid),
        .sb_addr           (sb_addr),
        .sb_wmask          (sb_wmask),
        .sb_wdata          (sb_wdata),
        .dmem_req_valid    (dmem_req_valid),
        .dmem_req_ready    (dmem_req_ready),
        .dmem_req_addr     (dmem_req_addr),
        .dmem_req_rmask    (dmem_req_rmask),
        .dmem_req_tag      (dmem_req_tag),
        .dmem_resp_valid   (dmem_resp_valid),
        .dmem_resp_tag     (dmem_resp_tag),
        .dmem_resp_rdata   (dmem_resp_rdata),
        .cdb_out_valid     (cdb_out_valid),
        .cdb_out_ready     (cdb_out_ready),
        .cdb_out_rob       (cdb_out_rob),
        .cdb_out_v         (cdb_out_v),
        .cdb_out_addr      (cdb_out_addr),
        .cdb_out_rmask     (cdb_out_rmask),
        .cdb_out_rdata     (cdb_out_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] rs1,
                         input logic [31:0] imm, input logic [2:0] rob,
                         input logic rdy, input logic [2:0] tag,
                         input logic [3:0] cnt);
        issue_funct3      = f3;
        issue_rs1_v       = rs1;
        issue_imm         = imm;
        issue_target_rob  = rob;
        issue_rs1_ready   = rdy;
        issue_rs1_rob     = tag;
        issue_store_count = cnt;
        issue_valid       = 1'b1;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic resp(input int p, input logic [3:0] tag,
                        input logic [31:0] d);
        dmem_resp_valid[p] = 1'b1;
        dmem_resp_tag[p]   = tag;
        dmem_resp_rdata[p] = d;
    endtask

    task automatic get_cdb(input string tag, input logic [2:0] rob,
                           input logic [31:0] v);
        int k;
        k = 0;
        while (!cdb_out_valid && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_vld"}, 32'(cdb_out_valid), 32'd1);
        check({tag, "_rob"}, 32'(cdb_out_rob), 32'(rob));
        check({tag, "_v"}, cdb_out_v, v);
        tick();
    endtask

    task automatic sb_clear();
        sb_valid = '0;
        for (int s = 0; s < 8; s++) begin
            sb_addr[s]  = '0;
            sb_wmask[s] = '0;
            sb_wdata[s] = '0;
        end
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b0;
        move_flush = 1'b0;
        issue_valid = 1'b0;
        issue_funct3 = '0;
        issue_imm = '0;
        issue_target_rob = '0;
        issue_rs1_ready = 1'b0;
        issue_rs1_v = '0;
        issue_rs1_rob = '0;
        issue_store_count = '0;
        store_rs_pop = 1'b0;
        cdb_valid = '0;
        for (int c = 0; c < 4; c++) begin
            cdb_rob[c] = '0;
            cdb_rd_v[c] = '0;
        end
        sb_clear();
        dmem_req_ready = 2'b11;
        dmem_resp_valid = '0;
        for (int p = 0; p < 2; p++) begin
            dmem_resp_tag[p] = '0;
            dmem_resp_rdata[p] = '0;
        end
        cdb_out_ready = 1'b1;

        tick();
        tick();
        check("rst_irdy", 32'(issue_ready), 32'd1);
        check("rst_req", 32'(dmem_req_valid), 32'd0);
        check("rst_cvld", 32'(cdb_out_valid), 32'd0);
        check("rst_cv", cdb_out_v, 32'd0);
        rst = 1'b1;
        tick();

        // lw 0x100 via dmem
        issue(3'b010, 32'h100, 32'h0, 3'd1, 1'b1, 3'd0, 4'd0);
        check("t1_req", 32'(dmem_req_valid), 32'd1);
        check("t1_addr", dmem_req_addr[0], 32'h100);
        check("t1_rmask", 32'(dmem_req_rmask[0]), 32'hF);
        check("t1_tag", 32'(dmem_req_tag[0]), 32'd0);
        tick();
        resp(0, 4'd0, 32'hDEADBEEF);
        tick();
        dmem_resp_valid = '0;
        get_cdb("t1", 3'd1, 32'hDEADBEEF);

        // lb 0x103 fully forwarded
        sb_valid[0] = 1'b1;
        sb_addr[0] = 32'h100;
        sb_wmask[0] = 4'b1000;
        sb_wdata[0] = 32'h80000000;
        issue(3'b000, 32'h100, 32'h3, 3'd2, 1'b1, 3'd0, 4'd0);
        check("t2_noreq", 32'(dmem_req_valid), 32'd0);
        tick();
        check("t2_noreq2", 32'(dmem_req_valid), 32'd0);
        k_wait_addr: begin
            get_cdb("t2", 3'd2, 32'hFFFFFF80);
        end
        sb_clear();

        // lw 0x200 partial forward, youngest store wins
        sb_valid[1] = 1'b1;
        sb_addr[1] = 32'h200;
        sb_wmask[1] = 4'b0011;
        sb_wdata[1] = 32'h0000AAAA;
        sb_valid[2] = 1'b1;
        sb_addr[2] = 32'h200;
        sb_wmask[2] = 4'b0001;
        sb_wdata[2] = 32'h000000BB;
        issue(3'b010, 32'h200, 32'h0, 3'd3, 1'b1, 3'd0, 4'd0);
        check("t3_req", 32'(dmem_req_valid), 32'd1);
        check("t3_addr", dmem_req_addr[0], 32'h200);
        tick();
        sb_clear();
        resp(0, 4'd0, 32'h12345678);
        tick();
        dmem_resp_valid = '0;
        get_cdb("t3", 3'd3, 32'h1234AAAA);

        // two loads, dual issue, responses swapped, output held
        dmem_req_ready = 2'b00;
        issue(3'b010, 32'h300, 32'h0, 3'd1, 1'b1, 3'd0, 4'd0);
        issue(3'b010, 32'h304, 32'h0, 3'd2, 1'b1, 3'd0, 4'd0);
        check("t4_req", 32'(dmem_req_valid), 32'd3);
        check("t4_a0", dmem_req_addr[0], 32'h300);
        check("t4_a1", dmem_req_addr[1], 32'h304);
        check("t4_tg0", 32'(dmem_req_tag[0]), 32'd0);
        check("t4_tg1", 32'(dmem_req_tag[1]), 32'd1);
        dmem_req_ready = 2'b11;
        cdb_out_ready = 1'b0;
        tick();
        check("t4_drain", 32'(dmem_req_valid), 32'd0);
        resp(0, 4'd1, 32'hBBBB0000);
        resp(1, 4'd0, 32'hAAAA1111);
        tick();
        dmem_resp_valid = '0;
        tick();
        for (int c = 0; c < 3; c++) begin
            check("t4_hvld", 32'(cdb_out_valid), 32'd1);
            check("t4_hrob", 32'(cdb_out_rob), 32'd1);
            check("t4_hv", cdb_out_v, 32'hAAAA1111);
            if (c < 2) tick();
        end
        cdb_out_ready = 1'b1;
        tick();
        check("t4_2vld", 32'(cdb_out_valid), 32'd1);
        check("t4_2rob", 32'(cdb_out_rob), 32'd2);
        check("t4_2v", cdb_out_v, 32'hBBBB0000);
        tick();
        check("t4_empty", 32'(cdb_out_valid), 32'd0);

        // store count 2 and rs1 from CDB tag 5
        issue(3'b010, 32'h0, 32'h10, 3'd3, 1'b0, 3'd5, 4'd2);
        check("t5_w0", 32'(dmem_req_valid), 32'd0);
        store_rs_pop = 1'b1;
        tick();
        store_rs_pop = 1'b0;
        check("t5_w1", 32'(dmem_req_valid), 32'd0);
        store_rs_pop = 1'b1;
        tick();
        store_rs_pop = 1'b0;
        check("t5_w2", 32'(dmem_req_valid), 32'd0);
        cdb_valid = 4'b0101;
        cdb_rob[0] = 3'd4;
        cdb_rd_v[0] = 32'h999;
        cdb_rob[2] = 3'd5;
        cdb_rd_v[2] = 32'h400;
        tick();
        cdb_valid = '0;
        check("t5_w3", 32'(dmem_req_valid), 32'd0);
        tick();
        check("t5_req", 32'(dmem_req_valid), 32'd1);
        check("t5_addr", dmem_req_addr[0], 32'h410);
        tick();
        resp(0, 4'd0, 32'h55667788);
        tick();
        dmem_resp_valid = '0;
        get_cdb("t5", 3'd3, 32'h55667788);

        // flush with an issued load, stale responses dropped
        store_rs_pop = 1'b1;
        issue(3'b010, 32'h600, 32'h0, 3'd4, 1'b1, 3'd0, 4'd1);
        store_rs_pop = 1'b0;
        check("t6_req", 32'(dmem_req_valid), 32'd1);
        tick();
        move_flush = 1'b1;
        tick();
        move_flush = 1'b0;
        check("t6_fl_req", 32'(dmem_req_valid), 32'd0);
        check("t6_fl_irdy", 32'(issue_ready), 32'd1);
        resp(0, 4'd0, 32'h0BAD0BAD);
        tick();
        dmem_resp_valid = '0;
        issue(3'b010, 32'h700, 32'h0, 3'd5, 1'b1, 3'd0, 4'd0);
        check("t6_ntag", 32'(dmem_req_tag[0]), 32'd8);
        check("t6_naddr", dmem_req_addr[0], 32'h700);
        tick();
        resp(0, 4'd0, 32'h0BAD0BAD);
        tick();
        dmem_resp_valid = '0;
        tick();
        check("t6_stale", 32'(cdb_out_valid), 32'd0);
        resp(0, 4'd8, 32'h77777777);
        tick();
        dmem_resp_valid = '0;
        get_cdb("t6", 3'd5, 32'h77777777);

        // fill every entry
        for (int i = 0; i < 8; i++) begin
            issue(3'b010, 32'h0, 32'h0, 3'd7, 1'b0, 3'd6, 4'd0);
        end
        check("full_irdy", 32'(issue_ready), 32'd0);
        check("full_req", 32'(dmem_req_valid), 32'd0);
        move_flush = 1'b1;
        tick();
        move_flush = 1'b0;
        check("full_fl", 32'(issue_ready), 32'd1);

        // lh forwarded, held output, then async reset
        sb_valid[0] = 1'b1;
        sb_addr[0] = 32'h100;
        sb_wmask[0] = 4'b1100;
        sb_wdata[0] = 32'h80010000;
        cdb_out_ready = 1'b0;
        issue(3'b001, 32'h100, 32'h2, 3'd6, 1'b1, 3'd0, 4'd0);
        get_cdb("t7", 3'd6, 32'hFFFF8001);
        check("t7_rmask", 32'(cdb_out_rmask), 32'hC);
        check("t7_addr", cdb_out_addr, 32'h102);
        sb_clear();
        dmem_req_ready = 2'b00;
        issue(3'b010, 32'h900, 32'h0, 3'd7, 1'b1, 3'd0, 4'd0);
        check("t7_pend", 32'(dmem_req_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_cvld", 32'(cdb_out_valid), 32'd0);
        check("ar_cv", cdb_out_v, 32'd0);
        check("ar_req", 32'(dmem_req_valid), 32'd0);
        check("ar_irdy", 32'(issue_ready), 32'd1);
        rst = 1'b1;
        tick();
        check("ar_post", 32'(cdb_out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
